// File: rtl/aes_pkg.sv
// Shared AES constants and helpers: S-box table, GF(2^8) xtime,
// key-length derivations and the key-schedule state encoding.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, GEN, DRAIN} ks_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic int nk_of(input int key_bits);
    return key_bits / 32;
  endfunction

  function automatic int nr_of(input int key_bits);
    return key_bits / 32 + 6;
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: four parallel S-box lookups on a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  assign word_out = {sbox(word_in[31:24]), sbox(word_in[23:16]),
                     sbox(word_in[15:8]),  sbox(word_in[7:0])};

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES key expander: one schedule word per cycle, round keys
// delivered on a valid/ready stream with back-pressure.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                busy,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [127:0]        rk_out,
  output logic [3:0]          rk_index,
  output logic                rk_last
);

  localparam int         NK     = nk_of(KEY_BITS);
  localparam int         NR     = nr_of(KEY_BITS);
  localparam logic [5:0] NK_W   = 6'(NK);
  localparam logic [5:0] LAST_W = 6'(4 * NR + 3);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
    $error("aes_key_schedule: KEY_BITS must be 128, 192 or 256");
  end

  ks_state_e           state_q, state_d;
  logic [5:0]          i_q, i_d;
  logic [7:0]          rcon_q, rcon_d;
  logic [KEY_BITS-1:0] win_q, win_d;
  logic [95:0]         asm_q, asm_d;
  logic                rk_valid_q, rk_valid_d;
  logic [127:0]        rk_out_q, rk_out_d;
  logic [3:0]          rk_index_q, rk_index_d;
  logic                rk_last_q, rk_last_d;

  logic        handshake, stall, commit, group_done, last_word;
  logic        is_rcon_pos, is_sub_pos;
  logic [5:0]  i_mod;
  logic [31:0] prev_w, old_w, sub_in, sub_out, t_w, new_w;

  // Window holds the last NK words: MSB word is w[i-NK], LSB word is w[i-1].
  assign prev_w = win_q[31:0];
  assign old_w  = win_q[KEY_BITS-1 -: 32];

  aes_sub_word u_sub_word (
    .word_in  (sub_in),
    .word_out (sub_out)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    handshake   = rk_valid_q && rk_ready;
    stall       = rk_valid_q && !rk_ready;
    commit      = (state_q == GEN) && !stall;
    i_mod       = i_q % NK_W;
    last_word   = (i_q == LAST_W);
    is_rcon_pos = (i_q >= NK_W) && (i_mod == 6'd0);
    is_sub_pos  = (NK == 8) && (i_q >= NK_W) && (i_mod == 6'd4);
    sub_in      = is_rcon_pos ? {prev_w[23:0], prev_w[31:24]} : prev_w;

    if (is_rcon_pos)     t_w = sub_out ^ {rcon_q, 24'h0};
    else if (is_sub_pos) t_w = sub_out;
    else                 t_w = prev_w;

    // While i < NK the window rotates the key words straight through.
    new_w      = (i_q < NK_W) ? old_w : (old_w ^ t_w);
    group_done = commit && (i_q[1:0] == 2'b11);

    state_d    = state_q;
    i_d        = i_q;
    rcon_d     = rcon_q;
    win_d      = win_q;
    asm_d      = asm_q;
    rk_valid_d = rk_valid_q;
    rk_out_d   = rk_out_q;
    rk_index_d = rk_index_q;
    rk_last_d  = rk_last_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = GEN;
          win_d   = key_in;
          i_d     = 6'd0;
          rcon_d  = 8'h01;
        end
      end
      GEN: begin
        if (commit) begin
          win_d = {win_q[KEY_BITS-33:0], new_w};
          asm_d = {asm_q[63:0], new_w};
          if (is_rcon_pos) rcon_d = xtime(rcon_q);
          if (last_word) state_d = DRAIN;
          else           i_d     = i_q + 6'd1;
        end
      end
      DRAIN: begin
        if (handshake) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A completing group wins over a same-cycle handshake: no bubble.
    if (group_done) begin
      rk_valid_d = 1'b1;
      rk_out_d   = {asm_q, new_w};
      rk_index_d = i_q[5:2];
      rk_last_d  = last_word;
    end else if (handshake) begin
      rk_valid_d = 1'b0;
      rk_last_d  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      i_q        <= 6'd0;
      rcon_q     <= 8'h00;
      rk_valid_q <= 1'b0;
      rk_out_q   <= 128'h0;
      rk_index_q <= 4'd0;
      rk_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      rcon_q     <= rcon_d;
      rk_valid_q <= rk_valid_d;
      rk_out_q   <= rk_out_d;
      rk_index_q <= rk_index_d;
      rk_last_q  <= rk_last_d;
    end
  end

  // NOTE: window and assembly storage are left unreset; they are always written before being read.
  always_ff @(posedge clk) begin
    win_q <= win_d;
    asm_q <= asm_d;
  end

  assign busy     = (state_q != IDLE);
  assign rk_valid = rk_valid_q;
  assign rk_out   = rk_out_q;
  assign rk_index = rk_index_q;
  assign rk_last  = rk_last_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule: FIPS-197 vectors for all three key
// lengths, back-pressure, ignored start, mid-run reset and back-to-back runs.
module tb_aes_key_schedule;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic         start128, rdy128, busy128, valid128, last128;
  logic [127:0] key128, out128;
  logic [3:0]   idx128;

  logic         start192, rdy192, busy192, valid192, last192;
  logic [191:0] key192;
  logic [127:0] out192;
  logic [3:0]   idx192;

  logic         start256, rdy256, busy256, valid256, last256;
  logic [255:0] key256;
  logic [127:0] out256;
  logic [3:0]   idx256;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] K128     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K128_ALT = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K192     = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256     = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R192_12  = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] R256_14  = 128'hfe4890d1e6188d0b046df344706c631e;

  localparam logic [127:0] EXP128 [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  aes_key_schedule #(.KEY_BITS(128)) dut128 (
    .clk(clk), .rst(rst), .start(start128), .key_in(key128), .busy(busy128),
    .rk_valid(valid128), .rk_ready(rdy128), .rk_out(out128), .rk_index(idx128), .rk_last(last128)
  );

  aes_key_schedule #(.KEY_BITS(192)) dut192 (
    .clk(clk), .rst(rst), .start(start192), .key_in(key192), .busy(busy192),
    .rk_valid(valid192), .rk_ready(rdy192), .rk_out(out192), .rk_index(idx192), .rk_last(last192)
  );

  aes_key_schedule #(.KEY_BITS(256)) dut256 (
    .clk(clk), .rst(rst), .start(start256), .key_in(key256), .busy(busy256),
    .rk_valid(valid256), .rk_ready(rdy256), .rk_out(out256), .rk_index(idx256), .rk_last(last256)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; launches a 128-bit run and follows it to completion.
  task automatic run_128(input int low_pct, input bit poke, input int abort_at);
    int next_g;
    int stalls;
    bit done;
    bit prev_stall;
    bit rdy;
    next_g     = 0;
    stalls     = 0;
    done       = 1'b0;
    prev_stall = 1'b0;
    key128     = K128;
    start128   = 1'b1;
    @(negedge clk);
    start128 = 1'b0;
    for (int k = 1; k <= 400 && !done; k++) begin
      if (k == 1) check("busy_rise", 128'(busy128), 128'd1);
      if (abort_at != 0 && k == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_valid", 128'(valid128), 128'd0);
        check("abort_busy", 128'(busy128), 128'd0);
        return;
      end
      if (poke && k == 10) begin
        key128   = K128_ALT;
        start128 = 1'b1;
      end
      if (poke && k == 11) start128 = 1'b0;
      if (prev_stall) check("stall_hold_valid", 128'(valid128), 128'd1);
      rdy = ($urandom_range(99) >= low_pct);
      if (valid128) begin
        check($sformatf("rk%0d_out", next_g), out128, EXP128[next_g]);
        check($sformatf("rk%0d_index", next_g), 128'(idx128), 128'(next_g));
        check($sformatf("rk%0d_last", next_g), 128'(last128), 128'(next_g == 10));
        if (rdy) begin
          check($sformatf("rk%0d_cycle", next_g), 128'(k), 128'(5 + 4 * next_g + stalls));
          if (next_g == 10) begin
            done = 1'b1;
            check("total_cycles", 128'(k), 128'(45 + stalls));
          end
          next_g++;
        end
      end
      prev_stall = valid128 && !rdy;
      if (prev_stall) stalls++;
      rdy128 = rdy;
      @(negedge clk);
    end
    if (!done) check("rk128_timeout", 128'd0, 128'd1);
    check("busy_fall", 128'(busy128), 128'd0);
    check("valid_fall", 128'(valid128), 128'd0);
  endtask

  // Unthrottled run of the 192-bit (w256=0) or 256-bit (w256=1) instance.
  task automatic run_wide(input bit w256);
    int nr;
    int next_g;
    bit done;
    logic         v, l;
    logic [127:0] o;
    logic [3:0]   ix;
    nr     = w256 ? 14 : 12;
    next_g = 0;
    done   = 1'b0;
    key192 = K192;
    key256 = K256;
    rdy192 = 1'b1;
    rdy256 = 1'b1;
    if (w256) start256 = 1'b1;
    else      start192 = 1'b1;
    @(negedge clk);
    start192 = 1'b0;
    start256 = 1'b0;
    for (int k = 1; k <= 200 && !done; k++) begin
      v  = w256 ? valid256 : valid192;
      o  = w256 ? out256   : out192;
      ix = w256 ? idx256   : idx192;
      l  = w256 ? last256  : last192;
      if (v) begin
        check($sformatf("w%0d_rk%0d_index", w256, next_g), 128'(ix), 128'(next_g));
        check($sformatf("w%0d_rk%0d_last", w256, next_g), 128'(l), 128'(next_g == nr));
        check($sformatf("w%0d_rk%0d_cycle", w256, next_g), 128'(k), 128'(5 + 4 * next_g));
        if (next_g == 0) check($sformatf("w%0d_rk0", w256), o, w256 ? key256[255:128] : key192[191:64]);
        if (w256 && next_g == 1) check("w1_rk1", o, key256[127:0]);
        if (next_g == nr) begin
          check($sformatf("w%0d_rk_final", w256), o, w256 ? R256_14 : R192_12);
          done = 1'b1;
        end
        next_g++;
      end
      @(negedge clk);
    end
    if (!done) check($sformatf("w%0d_timeout", w256), 128'd0, 128'd1);
    check($sformatf("w%0d_busy_fall", w256), 128'(w256 ? busy256 : busy192), 128'd0);
  endtask

  initial begin
    rst      = 1'b1;
    start128 = 1'b0;
    start192 = 1'b0;
    start256 = 1'b0;
    rdy128   = 1'b0;
    rdy192   = 1'b0;
    rdy256   = 1'b0;
    key128   = '0;
    key192   = '0;
    key256   = '0;
    repeat (3) @(negedge clk);

    check("rst_valid", 128'(valid128), 128'd0);
    check("rst_busy", 128'(busy128), 128'd0);
    check("rst_last", 128'(last128), 128'd0);
    check("rst_out", out128, 128'd0);
    check("rst_index", 128'(idx128), 128'd0);
    check("rst_busy192", 128'(busy192), 128'd0);
    check("rst_valid256", 128'(valid256), 128'd0);
    rst = 1'b0;

    run_128(0, 1'b0, 0);
    run_128(40, 1'b0, 0);
    run_128(0, 1'b1, 0);
    run_128(0, 1'b0, 20);
    check("post_abort_out", out128, 128'd0);
    run_128(0, 1'b0, 0);
    run_wide(1'b0);
    run_wide(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Parametrised, iterative AES key expander for 128-, 192- and 256-bit keys. It produces the full round-key sequence (rk0..rkNr), computing one 32-bit schedule word per cycle. Each 128-bit round key is delivered over a valid/ready stream with back-pressure. It feeds iterative or pipelined AES round datapaths that need keys longer than 128 bits, which the fixed 128-bit unrolled expanders cannot serve.

## Interface
- KEY_BITS, 128 — key length; legal values 128, 192, 256. Any other value is an elaboration error.
- NK (derived), KEY_BITS/32 — key words: 4, 6 or 8.
- NR (derived), NK+6 — round count: 10, 12 or 14.
- clk  in  1 — single clock; all state updates on its rising edge.
- rst  in  1 — reset, synchronous, active-high.
- start  in  1 — request expansion of key_in; accepted only when busy=0.
- key_in  in  KEY_BITS — cipher key, word 0 in the MSBs; sampled only in the accept cycle.
- busy  out  1 — high from the cycle after accept until the final round key is consumed.
- rk_valid  out  1 — rk_out/rk_index hold a round key.
- rk_ready  in  1 — consumer accepts the round key when rk_valid && rk_ready.
- rk_out  out  128 — round key {w[4g], w[4g+1], w[4g+2], w[4g+3]}.
- rk_index  out  4 — round-key number g, 0..NR.
- rk_last  out  1 — high with rk_valid when g == NR.

## Operation
- FSM states:
  - IDLE → GEN on start.
  - GEN → DRAIN after word 4·NR+3 is committed.
  - DRAIN → IDLE on the final rk handshake.
- Accept (IDLE && start):
  - Load an NK-word window register with key_in.
  - Set word counter i = 0 and rcon = 0x01.
- GEN, one word committed per non-stalled cycle:
  - For i < NK: w[i] = key word i.
  - Otherwise, with t = w[i-1]:
    - if i mod NK == 0: t = SubWord(RotWord(t)) ^ {rcon, 24'h0}, then rcon = xtime(rcon) (shift left 1; XOR 0x1b when bit7 was set).
    - else if NK == 8 and i mod NK == 4: t = SubWord(t).
    - w[i] = w[i-NK] ^ t.
  - Each committed word shifts into the window (oldest out) and into a 4-word assembly register.
- Every 4th committed word (i mod 4 == 3):
  - Load the assembly into rk_out.
  - Set rk_index = i/4 and raise rk_valid.
- Stall: when rk_valid && !rk_ready, no word is committed, and the counter, window and rcon hold. rk_out, rk_index and rk_last stay stable until the handshake.
- A handshake and a new group completing in the same cycle load the new key with rk_valid staying high (no bubble).
- Counter width is 6 bits; the last word index is 4·NR+3 (43, 51 or 59). Never wrap; the counter freezes in DRAIN.
- start while busy=1 is ignored; no queueing.
- Reset values: rk_valid=0, busy=0, rk_last=0, rk_out=0, rk_index=0, state IDLE.
- rst mid-expansion aborts the run immediately. There is no partial output after reset.

## Timing
- Accept on the edge ending cycle T; busy=1 from cycle T+1.
- With rk_ready held high:
  - Word i is committed at the edge ending cycle T+1+i.
  - rkg is valid in cycle T+5+4g.
  - rk_last appears in cycle T+5+4·NR: T+45, T+53 or T+61 for 128, 192 and 256-bit keys.
- busy falls in the cycle after the final handshake. A new start is accepted in that same cycle (busy=0).
- Each rk_ready=0 cycle while rk_valid=1 delays all later keys by exactly one cycle.
- SubWord is combinational in the same cycle (4 S-box lookups); there is no multicycle path.

## Structure
- Shared package aes_pkg:
  - The AES S-box constant table.
  - An xtime function.
  - The KEY_BITS → NK/NR derivation functions.
  - The state enum {IDLE, GEN, DRAIN}.
- Sub-module aes_sub_word: combinational 32-bit SubWord built from four package S-box lookups. Reused by future iterative round datapaths.

## Test plan
- KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
  - rk1 = a0fafe1788542cb123a339392a6c7605 at T+9.
  - rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last at T+45.
- KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b: rk12 = e98ba06f448c773c8ecc720401002202, rk_index=12, rk_last=1 at T+53.
- KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - rk1 = 1f352c073b6108d72d9810a30914dff4.
  - rk14 = fe4890d1e6188d0b046df344706c631e at T+61.
- Random rk_ready throttling (~40% low) on the 128-bit vector:
  - All 11 keys match the unthrottled run in order.
  - rk_out is stable while stalled.
  - Total cycles = 45 + number of stall cycles.
- start pulsed while busy, with a different key: ignored; the outputs still match the first key.
- rst asserted at T+20:
  - Next cycle rk_valid=0 and busy=0.
  - A fresh start then yields the correct rk0..rk10 from T'+5.
